control_cmd_readrows: RTL and testbench



---
 rtl/control_cmd_readrows.sv | 181 ++++++++++++++++++
 tb/tb_control_cmd_readrows.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_readrows.sv
// Consumes the payload of a "write N rows" command (row_start, row_count, pixel bytes)
// and turns each pixel byte into one framebuffer RAM write, row by row.
module control_cmd_readrows #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int MAX_ROWS        = 8,
  localparam int ROW_W  = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int COL_W  = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int PIX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int ADDR_W = ROW_W + COL_W + PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              ram_write_enable,
  output logic              ram_access_start,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(MAX_ROWS + 1);

  localparam logic [7:0]       MAX_ROWS_B = 8'(MAX_ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(PIXEL_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(PIXEL_WIDTH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(BYTES_PER_PIXEL - 1);
  localparam logic [ROW_W:0]   ROW_MOD    = (ROW_W + 1)'(PIXEL_HEIGHT);

  typedef enum logic [1:0] {
    CAP_ROW,
    CAP_CNT,
    DATA,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CNT_W-1:0]   rows_left_q, rows_left_d;
  logic               err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               we_q, we_d;
  logic               as_q, as_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  // A truncated row byte is below 2*PIXEL_HEIGHT, so one conditional subtract is a full modulo.
  logic [ROW_W:0]   row_trunc;
  logic [ROW_W-1:0] row_mod;

  always_comb begin
    row_trunc = {1'b0, data_in[ROW_W-1:0]};
    row_mod   = (row_trunc >= ROW_MOD) ? ROW_W'(row_trunc - ROW_MOD) : row_trunc[ROW_W-1:0];
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_d       = pix_q;
    rows_left_d = rows_left_q;
    err_flag_d  = err_flag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = we_q;
    as_d        = as_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      CAP_ROW: begin
        if (enable) begin
          row_d   = row_mod;
          addr_d  = {row_mod, {COL_W{1'b0}}, {PIX_W{1'b0}}};
          we_d    = 1'b0;
          data_d  = 8'h00;
          state_d = CAP_CNT;
        end
      end

      CAP_CNT: begin
        if (enable) begin
          if (data_in == 8'h00 || data_in > MAX_ROWS_B) begin
            err_flag_d = 1'b1;
            state_d    = DONE;
          end else begin
            rows_left_d = data_in[CNT_W-1:0];
            col_d       = COL_LAST;
            pix_d       = PIX_LAST;
            state_d     = DATA;
          end
        end
      end

      DATA: begin
        if (enable) begin
          addr_d = {row_q, col_q, pix_q};
          data_d = data_in;
          we_d   = 1'b1;
          as_d   = ~as_q;
          // Pixel byte counts fastest, then column (right to left), then row.
          if (pix_q != '0) begin
            pix_d = pix_q - 1'b1;
          end else begin
            pix_d = PIX_LAST;
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
            end else begin
              col_d       = COL_LAST;
              row_d       = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
              rows_left_d = rows_left_q - 1'b1;
              if (rows_left_q == CNT_W'(1)) state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        done_d     = 1'b1;
        error_d    = err_flag_q;
        we_d       = 1'b0;
        data_d     = 8'h00;
        err_flag_d = 1'b0;
        state_d    = CAP_ROW;
        // The host may already be sending the next command's row byte.
        if (enable) begin
          row_d   = row_mod;
          state_d = CAP_CNT;
        end
      end

      default: state_d = CAP_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= CAP_ROW;
      row_q       <= '0;
      col_q       <= '0;
      pix_q       <= '0;
      rows_left_q <= '0;
      err_flag_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= 8'h00;
      we_q        <= 1'b0;
      as_q        <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_q       <= pix_d;
      rows_left_q <= rows_left_d;
      err_flag_q  <= err_flag_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      as_q        <= as_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign addr             = addr_q;
  assign data_out         = data_q;
  assign ram_write_enable = we_q;
  assign ram_access_start = as_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_control_cmd_readrows.sv
// Self-checking bench for control_cmd_readrows: a command table drives the byte stream while a
// negedge monitor scores every RAM write and done/error pulse against bench-built expectations.
module tb_control_cmd_readrows;

  localparam int PW     = 4;
  localparam int PH     = 8;
  localparam int BPP    = 2;
  localparam int MR     = 4;
  localparam int ROW_W  = $clog2(PH);
  localparam int COL_W  = $clog2(PW);
  localparam int PIX_W  = $clog2(BPP);
  localparam int ADDR_W = ROW_W + COL_W + PIX_W;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_out;
  logic              ram_write_enable;
  logic              ram_access_start;
  logic              done;
  logic              error;

  control_cmd_readrows #(
    .PIXEL_WIDTH    (PW),
    .PIXEL_HEIGHT   (PH),
    .BYTES_PER_PIXEL(BPP),
    .MAX_ROWS       (MR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .data_in         (data_in),
    .addr            (addr),
    .data_out        (data_out),
    .ram_write_enable(ram_write_enable),
    .ram_access_start(ram_access_start),
    .done            (done),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  // gap < 0 selects a random 0..20 cycle gap after every byte.
  typedef struct {
    logic [7:0] row;
    logic [7:0] cnt;
    logic [7:0] base;
    bit         err;
    int         gap;
    bit         chk_row;
    int         drain;
  } cmd_t;

  wr_t exp_wr[$];
  bit  exp_done[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  done_count = 0;
  int  exp_done_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [7:0] row_b, input logic [7:0] cnt_b,
                          input logic [7:0] base, input bit err);
    int  r0;
    int  idx;
    wr_t w;
    r0  = int'(row_b[ROW_W-1:0]) % PH;
    idx = 0;
    if (!err) begin
      for (int r = 0; r < int'(cnt_b); r++)
        for (int c = PW - 1; c >= 0; c--)
          for (int p = BPP - 1; p >= 0; p--) begin
            w.addr = {ROW_W'((r0 + r) % PH), COL_W'(c), PIX_W'(p)};
            w.data = 8'(int'(base) + idx);
            exp_wr.push_back(w);
            idx++;
          end
    end
    exp_done.push_back(err);
    exp_done_total++;
  endtask

  // Called at posedge+1; leaves enable low at posedge+1 after the sampling edge and the gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    enable  = 1'b1;
    data_in = b;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(20, 0)) : g;
  endfunction

  // Monitor: writes are recognised by the access-start toggle; between writes outputs must hold.
  logic              prev_as;
  logic              prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]        prev_data;
  bit                rst_seen = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      rst_seen = 1'b1;
    end else if (rst_seen) begin
      rst_seen = 1'b0;
    end else begin
      if (ram_access_start !== prev_as) begin
        check("we_on_write", 32'(ram_write_enable), 32'd1);
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write_unexpected: got addr %0h data %0h, expected no write at %0t",
                   addr, data_out, $time);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_addr_data", 32'({addr, data_out}), 32'({w.addr, w.data}));
        end
      end else if (prev_we && !done) begin
        check("hold", 32'({ram_write_enable, addr, data_out}), 32'({1'b1, prev_addr, prev_data}));
      end
      if (done) begin
        done_count++;
        check("done_we_data", 32'({ram_write_enable, data_out}), 32'd0);
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1, expected none at %0t", $time);
        end else begin
          bit e;
          e = exp_done.pop_front();
          check("done_error", 32'(error), 32'(e));
        end
      end else begin
        check("error_without_done", 32'(error), 32'd0);
      end
    end
    prev_as   = ram_access_start;
    prev_we   = ram_write_enable;
    prev_addr = addr;
    prev_data = data_out;
  end

  cmd_t tbl[8];

  initial begin
    tbl[0] = '{row: 8'h02, cnt: 8'h01, base: 8'hAA, err: 1'b0, gap: 1,  chk_row: 1'b1, drain: 4};
    tbl[1] = '{row: 8'h07, cnt: 8'h02, base: 8'h10, err: 1'b0, gap: 0,  chk_row: 1'b1, drain: 4};
    tbl[2] = '{row: 8'h03, cnt: 8'h00, base: 8'h00, err: 1'b1, gap: 0,  chk_row: 1'b1, drain: 3};
    tbl[3] = '{row: 8'h03, cnt: 8'h05, base: 8'h00, err: 1'b1, gap: 0,  chk_row: 1'b1, drain: 3};
    tbl[4] = '{row: 8'h03, cnt: 8'h01, base: 8'h50, err: 1'b0, gap: 0,  chk_row: 1'b1, drain: 4};
    tbl[5] = '{row: 8'h05, cnt: 8'h01, base: 8'h60, err: 1'b0, gap: 0,  chk_row: 1'b1, drain: 0};
    tbl[6] = '{row: 8'h06, cnt: 8'h01, base: 8'h70, err: 1'b0, gap: 0,  chk_row: 1'b0, drain: 4};
    tbl[7] = '{row: 8'h02, cnt: 8'h01, base: 8'hAA, err: 1'b0, gap: -1, chk_row: 1'b1, drain: 4};

    reset   = 1'b1;
    enable  = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_outputs",
          32'({addr, data_out, ram_write_enable, ram_access_start, done, error}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      push_cmd(tbl[i].row, tbl[i].cnt, tbl[i].base, tbl[i].err);
      send_byte(tbl[i].row, pick_gap(tbl[i].gap));
      if (tbl[i].chk_row)
        check("row_capture", 32'(addr[ADDR_W-1 -: ROW_W]), 32'(tbl[i].row[ROW_W-1:0]));
      if (tbl[i].err) begin
        send_byte(tbl[i].cnt, 0);
        idle(1);
        check("reject_done_error", 32'({done, error}), 32'b11);
      end else begin
        int n;
        send_byte(tbl[i].cnt, pick_gap(tbl[i].gap));
        n = int'(tbl[i].cnt) * PW * BPP;
        for (int k = 0; k < n; k++)
          send_byte(8'(int'(tbl[i].base) + k), pick_gap(tbl[i].gap));
      end
      idle(tbl[i].drain);
    end

    // Reset in the middle of a command's data bytes.
    push_cmd(8'h04, 8'h02, 8'h30, 1'b0);
    send_byte(8'h04, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h30 + k), 0);
    idle(1);
    reset = 1'b1;
    exp_wr.delete();
    exp_done.delete();
    exp_done_total--;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midcmd_reset_outputs",
          32'({addr, data_out, ram_write_enable, ram_access_start, done, error}), 32'd0);

    push_cmd(8'h01, 8'h01, 8'hC0, 1'b0);
    send_byte(8'h01, 0);
    check("row_capture_after_reset", 32'(addr[ADDR_W-1 -: ROW_W]), 32'd1);
    send_byte(8'h01, 0);
    for (int k = 0; k < PW * BPP; k++) send_byte(8'(8'hC0 + k), 1);
    idle(6);

    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("dones_outstanding", 32'(exp_done.size()), 32'd0);
    check("done_count", 32'(done_count), 32'(exp_done_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
